// File: rtl/simple_system_bus_rr_if.sv
// Host- and device-side signals of the multi-host system bus.
// Suffixes are from the bus point of view: _i flows into the bus.
interface simple_system_bus_rr_if #(
    parameter int NrHosts      = 2,
    parameter int NrDevices    = 3,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    localparam int BeW = DataWidth / 8;

    logic                    host_req_i    [NrHosts];
    logic                    host_gnt_o    [NrHosts];
    logic [AddressWidth-1:0] host_addr_i   [NrHosts];
    logic                    host_we_i     [NrHosts];
    logic [BeW-1:0]          host_be_i     [NrHosts];
    logic [DataWidth-1:0]    host_wdata_i  [NrHosts];
    logic                    host_rvalid_o [NrHosts];
    logic [DataWidth-1:0]    host_rdata_o  [NrHosts];
    logic                    host_err_o    [NrHosts];

    logic                    device_req_o    [NrDevices];
    logic [AddressWidth-1:0] device_addr_o   [NrDevices];
    logic                    device_we_o     [NrDevices];
    logic [BeW-1:0]          device_be_o     [NrDevices];
    logic [DataWidth-1:0]    device_wdata_o  [NrDevices];
    logic                    device_rvalid_i [NrDevices];
    logic [DataWidth-1:0]    device_rdata_i  [NrDevices];
    logic                    device_err_i    [NrDevices];

    logic [AddressWidth-1:0] cfg_device_addr_base_i [NrDevices];
    logic [AddressWidth-1:0] cfg_device_addr_mask_i [NrDevices];

    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output device_req_o, device_addr_o, device_we_o, device_be_o,
        output device_wdata_o,
        input  device_rvalid_i, device_rdata_i, device_err_i,
        input  cfg_device_addr_base_i, cfg_device_addr_mask_i
    );

    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  device_req_o, device_addr_o, device_we_o, device_be_o,
        input  device_wdata_o,
        output device_rvalid_i, device_rdata_i, device_err_i,
        output cfg_device_addr_base_i, cfg_device_addr_mask_i
    );
endinterface

// File: rtl/simple_system_bus_rr.sv
// Multi-host round-robin system bus, one outstanding transaction,
// with address decode errors and a response timeout.
module simple_system_bus_rr #(
    parameter int NrHosts       = 2,
    parameter int NrDevices     = 3,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = 16
) (
    input logic                   clk_i,
    input logic                   rst_i,
    simple_system_bus_rr_if.slave bus
);
    localparam int HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
    localparam int CntW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam int BeW   = DataWidth / 8;
    localparam logic [CntW-1:0] CntLast =
        CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StWait   = 2'd1;
    localparam logic [1:0] StDecErr = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [HostW-1:0] rr_ptr_q, rr_ptr_d;
    logic [HostW-1:0] host_q, host_d;
    logic [DevW-1:0]  dev_q, dev_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             any_req;
    logic [HostW-1:0] win;
    logic             hit;
    logic [DevW-1:0]  hit_dev;

    logic                    gnt    [NrHosts];
    logic                    rvalid [NrHosts];
    logic [DataWidth-1:0]    rdata  [NrHosts];
    logic                    err    [NrHosts];
    logic                    dreq   [NrDevices];
    logic [AddressWidth-1:0] daddr  [NrDevices];
    logic                    dwe    [NrDevices];
    logic [BeW-1:0]          dbe    [NrDevices];
    logic [DataWidth-1:0]    dwdata [NrDevices];

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        int idx;
        idx     = 0;
        any_req = 1'b0;
        win     = '0;
        for (int i = 0; i < NrHosts; i++) begin
            idx = (int'(rr_ptr_q) + i) % NrHosts;
            if (!any_req && bus.host_req_i[idx]) begin
                any_req = 1'b1;
                win     = HostW'(idx);
            end
        end
    end

    // Downward scan so the lowest matching device index wins.
    always_comb begin
        hit     = 1'b0;
        hit_dev = '0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((bus.host_addr_i[win] & bus.cfg_device_addr_mask_i[d])
                == bus.cfg_device_addr_base_i[d]) begin
                hit     = 1'b1;
                hit_dev = DevW'(d);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        host_d   = host_q;
        dev_d    = dev_q;
        cnt_d    = cnt_q;
        for (int h = 0; h < NrHosts; h++) begin
            gnt[h]    = 1'b0;
            rvalid[h] = 1'b0;
            rdata[h]  = '0;
            err[h]    = 1'b0;
        end
        for (int d = 0; d < NrDevices; d++) begin
            dreq[d]   = 1'b0;
            daddr[d]  = '0;
            dwe[d]    = 1'b0;
            dbe[d]    = '0;
            dwdata[d] = '0;
        end
        if (!rst_i) begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        gnt[win] = 1'b1;
                        rr_ptr_d = HostW'((int'(win) + 1) % NrHosts);
                        host_d   = win;
                        dev_d    = hit_dev;
                        cnt_d    = '0;
                        if (hit) begin
                            dreq[hit_dev]   = 1'b1;
                            daddr[hit_dev]  = bus.host_addr_i[win];
                            dwe[hit_dev]    = bus.host_we_i[win];
                            dbe[hit_dev]    = bus.host_be_i[win];
                            dwdata[hit_dev] = bus.host_wdata_i[win];
                            state_d         = StWait;
                        end else begin
                            state_d = StDecErr;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    // A real response beats a timeout in the same cycle.
                    if (bus.device_rvalid_i[dev_q]) begin
                        rvalid[host_q] = 1'b1;
                        rdata[host_q]  = bus.device_rdata_i[dev_q];
                        err[host_q]    = bus.device_err_i[dev_q];
                        state_d        = StIdle;
                    end else if (TimeoutCycles != 0 && cnt_q == CntLast) begin
                        rvalid[host_q] = 1'b1;
                        err[host_q]    = 1'b1;
                        state_d        = StIdle;
                    end
                end
                StDecErr: begin
                    rvalid[host_q] = 1'b1;
                    err[host_q]    = 1'b1;
                    state_d        = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            host_q   <= '0;
            dev_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            host_q   <= host_d;
            dev_q    <= dev_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.host_gnt_o     = gnt;
    assign bus.host_rvalid_o  = rvalid;
    assign bus.host_rdata_o   = rdata;
    assign bus.host_err_o     = err;
    assign bus.device_req_o   = dreq;
    assign bus.device_addr_o  = daddr;
    assign bus.device_we_o    = dwe;
    assign bus.device_be_o    = dbe;
    assign bus.device_wdata_o = dwdata;
endmodule

// File: tb/tb_simple_system_bus_rr.sv
// Scoreboard bench for simple_system_bus_rr: directed transactions
// push expected responses, a monitor pops them on every host rvalid.
module tb_simple_system_bus_rr;
    localparam int NH = 2;
    localparam int ND = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    typedef struct {
        int          host;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    simple_system_bus_rr_if #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW)
    ) bus ();

    simple_system_bus_rr #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(DW),
        .AddressWidth(AW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s @cyc %0d: got %h, expected %h", n, cyc, act, req);
    endtask

    function automatic logic [31:0] gnt_vec();
        logic [31:0] v = '0;
        for (int h = 0; h < NH; h++) v[h] = bus.host_gnt_o[h];
        return v;
    endfunction

    function automatic logic [31:0] dreq_vec();
        logic [31:0] v = '0;
        for (int d = 0; d < ND; d++) v[d] = bus.device_req_o[d];
        return v;
    endfunction

    function automatic logic [31:0] rv_vec();
        logic [31:0] v = '0;
        for (int h = 0; h < NH; h++) v[h] = bus.host_rvalid_o[h];
        return v;
    endfunction

    task automatic clear_dev();
        for (int d = 0; d < ND; d++) begin
            bus.device_rvalid_i[d] = 1'b0;
            bus.device_rdata_i[d]  = '0;
            bus.device_err_i[d]    = 1'b0;
        end
    endtask

    task automatic quiet();
        @(negedge clk);
        for (int h = 0; h < NH; h++) bus.host_req_i[h] = 1'b0;
        clear_dev();
    endtask

    // Monitor: every host rvalid must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            for (int h = 0; h < NH; h++) begin
                if (bus.host_rvalid_o[h]) begin
                    if (sb.size() == 0) begin
                        chk($sformatf("spurious_rvalid_h%0d", h),
                            bus.host_rvalid_o[h], 1'b0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_host", h, e.host);
                        chk("rsp_cycle", cyc, e.cyc);
                        chk("rsp_rdata", bus.host_rdata_o[h], e.data);
                        chk("rsp_err", bus.host_err_o[h], e.err);
                    end
                end
            end
        end
    end

    // One transaction from host h. d<0 means an unmapped address.
    // rv: cycle the device raises rvalid (0 = never).
    // ofrom: cycle from which the other host requests (-1 = never).
    task automatic xact(input int h, input logic [31:0] a, input logic we,
                        input logic [31:0] wd, input int d, input int rv,
                        input logic [31:0] rd, input logic de,
                        input int ofrom);
        int   o;
        int   c0;
        int   ecyc;
        int   last;
        exp_t e;
        o = (h + 1) % NH;
        @(negedge clk);
        clear_dev();
        c0 = cyc;
        bus.host_req_i[h]   = 1'b1;
        bus.host_addr_i[h]  = a;
        bus.host_we_i[h]    = we;
        bus.host_be_i[h]    = 4'hF;
        bus.host_wdata_i[h] = wd;
        bus.host_req_i[o]   = (ofrom == 0);
        e.host = h;
        if (d < 0) begin
            ecyc = 1; e.data = '0; e.err = 1'b1;
        end else if (rv != 0 && rv <= TO) begin
            ecyc = rv; e.data = rd; e.err = de;
        end else begin
            ecyc = TO; e.data = '0; e.err = 1'b1;
        end
        e.cyc = c0 + ecyc;
        #2;
        chk("grant", gnt_vec(), 32'(1) << h);
        chk("dev_req", dreq_vec(), (d < 0) ? 32'd0 : (32'(1) << d));
        if (d >= 0) begin
            chk("dev_addr", bus.device_addr_o[d], a);
            chk("dev_we", bus.device_we_o[d], we);
            chk("dev_be", bus.device_be_o[d], 4'hF);
            chk("dev_wdata", bus.device_wdata_o[d], wd);
        end
        sb.push_back(e);
        last = (rv > ecyc) ? rv : ecyc;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            clear_dev();
            bus.host_req_i[h] = (c <= ecyc);
            if (ofrom > 0 && c >= ofrom) bus.host_req_i[o] = 1'b1;
            if (c == rv && d >= 0) begin
                bus.device_rvalid_i[d] = 1'b1;
                bus.device_rdata_i[d]  = rd;
                bus.device_err_i[d]    = de;
            end
            #2;
            chk("no_grant_busy", gnt_vec(), 0);
            chk("no_dev_req_busy", dreq_vec(), 0);
        end
    endtask

    initial begin
        for (int h = 0; h < NH; h++) begin
            bus.host_req_i[h]   = 1'b0;
            bus.host_addr_i[h]  = '0;
            bus.host_we_i[h]    = 1'b0;
            bus.host_be_i[h]    = '0;
            bus.host_wdata_i[h] = '0;
        end
        clear_dev();
        bus.cfg_device_addr_base_i[0] = 32'h0010_0000;
        bus.cfg_device_addr_mask_i[0] = 32'hFFF0_0000;
        bus.cfg_device_addr_base_i[1] = 32'h0002_0000;
        bus.cfg_device_addr_mask_i[1] = 32'hFFFF_0000;
        bus.cfg_device_addr_base_i[2] = 32'h0003_0000;
        bus.cfg_device_addr_mask_i[2] = 32'hFFFF_0000;

        // Reset with a pending request: everything quiet.
        rst = 1'b1;
        bus.host_req_i[0]  = 1'b1;
        bus.host_addr_i[0] = 32'h0010_0000;
        @(negedge clk);
        #2;
        chk("rst_gnt", gnt_vec(), 0);
        chk("rst_dev_req", dreq_vec(), 0);
        chk("rst_rvalid", rv_vec(), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.host_req_i[0] = 1'b0;

        // Single write to RAM, 1-cycle device.
        xact(0, 32'h0010_0004, 1'b1, 32'hDEAD_BEEF, 0, 1, 32'h0, 1'b0, -1);
        // Decode miss.
        xact(1, 32'h0000_0000, 1'b0, 32'h0, -1, 0, 32'h0, 1'b0, -1);
        // Timeout, late rvalid at cycle 10 dropped.
        xact(0, 32'h0003_0000, 1'b0, 32'h0, 2, 10, 32'h1234_5678, 1'b0, -1);
        // Rvalid exactly in the timeout cycle wins.
        xact(0, 32'h0003_0000, 1'b0, 32'h0, 2, TO, 32'hCAFE_F00D, 1'b0, -1);
        // Device error is forwarded with its data.
        xact(1, 32'h0002_0010, 1'b0, 32'h0, 1, 2, 32'hA5A5_0001, 1'b1, -1);
        // 3-cycle device, host1 waits from cycle 1, granted in cycle 4.
        xact(0, 32'h0010_0020, 1'b0, 32'h0, 0, 3, 32'h0BAD_F00D, 1'b0, 1);
        xact(1, 32'h0010_0024, 1'b1, 32'h1111_2222, 0, 1, 32'h0, 1'b0, -1);
        // Continuous contention alternates 0,1,0,1.
        xact(0, 32'h0010_0100, 1'b0, 32'h0, 0, 1, 32'h0000_0A00, 1'b0, 0);
        xact(1, 32'h0010_0104, 1'b0, 32'h0, 0, 1, 32'h0000_0B01, 1'b0, 0);
        xact(0, 32'h0010_0108, 1'b0, 32'h0, 0, 1, 32'h0000_0A02, 1'b0, 0);
        xact(1, 32'h0010_010C, 1'b0, 32'h0, 0, 1, 32'h0000_0B03, 1'b0, 0);

        // Reset in cycle 2 of WAIT_RSP abandons the transaction.
        quiet();
        bus.host_req_i[0]  = 1'b1;
        bus.host_addr_i[0] = 32'h0003_0000;
        bus.host_we_i[0]   = 1'b0;
        #2;
        chk("mid_grant", gnt_vec(), 1);
        chk("mid_dev_req", dreq_vec(), 32'd4);
        @(negedge clk);
        bus.host_req_i[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("post_rst_gnt", gnt_vec(), 0);
        chk("post_rst_dev_req", dreq_vec(), 0);
        chk("post_rst_rvalid", rv_vec(), 0);
        @(negedge clk);
        bus.device_rvalid_i[2] = 1'b1;
        bus.device_rdata_i[2]  = 32'h5555_AAAA;
        #2;
        chk("stale_rvalid", rv_vec(), 0);
        quiet();
        // Pointer is back at 0: host0 wins over host1.
        xact(0, 32'h0010_0000, 1'b0, 32'h0, 0, 1, 32'h0000_0077, 1'b0, 0);

        // After reset, a lone host1 is granted immediately.
        quiet();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        xact(1, 32'h0002_0004, 1'b0, 32'h0, 1, 2, 32'h0000_0099, 1'b0, -1);

        quiet();
        quiet();
        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/simple_system_bus_rr.md
# simple_system_bus_rr

Multi-host, multi-device memory interconnect for the simple system that generalises the single-host bus. It supports a parametrised number of hosts with round-robin arbitration and variable device response latency. Unmapped addresses get a decode-error response, and a programmable timeout guards against devices that never respond. It sits between the core's data port plus additional hosts (DMA, debug) and the RAM, sim-control and timer devices.

## Interface
- `NrHosts`, default 2: number of host ports, at least 1.
- `NrDevices`, default 3: number of device ports, at least 1.
- `DataWidth`, default 32: data width.
- `AddressWidth`, default 32: address width.
- `TimeoutCycles`, default 16: response timeout in cycles after grant; 0 disables the timeout.

Ports (unpacked `[N]` arrays per host or device):
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `host_req_i`  in  1 `[NrHosts]`  request.
- `host_gnt_o`  out  1 `[NrHosts]`  grant.
- `host_addr_i`  in  AddressWidth `[NrHosts]`  byte address.
- `host_we_i`  in  1 `[NrHosts]`  write enable.
- `host_be_i`  in  DataWidth/8 `[NrHosts]`  byte enables.
- `host_wdata_i`  in  DataWidth `[NrHosts]`  write data.
- `host_rvalid_o`  out  1 `[NrHosts]`  response valid.
- `host_rdata_o`  out  DataWidth `[NrHosts]`  read data.
- `host_err_o`  out  1 `[NrHosts]`  response error.
- `device_req_o`, `device_addr_o`, `device_we_o`, `device_be_o`, `device_wdata_o`  out  `[NrDevices]`  request fields, same widths as the host side.
- `device_rvalid_i`  in  1 `[NrDevices]`  response valid.
- `device_rdata_i`  in  DataWidth `[NrDevices]`  read data.
- `device_err_i`  in  1 `[NrDevices]`  response error.
- `cfg_device_addr_base_i`  in  AddressWidth `[NrDevices]`  device base address.
- `cfg_device_addr_mask_i`  in  AddressWidth `[NrDevices]`  device address mask.

## Operation
- One transaction is outstanding system-wide. The FSM has three states: IDLE, WAIT_RSP and DECERR.
- **Decode:** device d hits when `(addr & mask[d]) == base[d]`. When several devices hit, the lowest index wins.
- **IDLE arbitration:** among asserted `host_req_i`, the winner is the first one found searching upward from `rr_ptr`, wrapping modulo NrHosts.
  - Assert `host_gnt_o[winner]` combinationally in the same cycle.
  - Set `rr_ptr <= (winner+1) % NrHosts`.
  - Latch the host index and the device index.
- **IDLE, hit:** drive `device_req_o[d]=1` and forward addr/we/be/wdata from the winner in the same cycle. Clear the timeout counter and go to WAIT_RSP.
- **IDLE, miss:** no `device_req_o` is asserted. Go to DECERR.
- **DECERR:** drive `host_rvalid_o[h]=1`, `host_err_o[h]=1`, `host_rdata_o[h]=0`, then return to IDLE.
- **WAIT_RSP, latched device responds:** when `device_rvalid_i[d]` is high, forward rvalid, rdata and err to host h combinationally, then go to IDLE.
- **WAIT_RSP, no response:** the counter increments each cycle.
- **WAIT_RSP, timeout:** when `TimeoutCycles!=0`, the counter equals `TimeoutCycles-1` and there is no rvalid, drive host h rvalid=1, err=1, rdata=0 and go to IDLE.
- **Timeout counter:** width is `$clog2(TimeoutCycles+1)`, minimum 1. It saturates and never wraps.
- **No grants outside IDLE:** no grants are issued in WAIT_RSP or DECERR, so requesting hosts hold their requests.
- **Ignored responses:** `device_rvalid_i` from non-latched devices, and any `device_rvalid_i` in IDLE or DECERR, is ignored. Late responses after a timeout are dropped.
- **Non-selected outputs:** all outputs for non-selected hosts and devices are 0, including data fields.

## Timing
- **Reset:** all outputs are 0. The FSM enters IDLE, `rr_ptr=0` and the counter is 0. Reset during WAIT_RSP or DECERR abandons the transaction: no response is ever returned, and a subsequent device rvalid is ignored.
- **Grant latency:** the grant occurs in the request cycle when the FSM is in IDLE.
- **Minimum response:** grant in cycle 0, response in cycle 1. Peak throughput is one transaction per 2 cycles.
- **Device latency:** a response from a device with k-cycle latency (k ≥ 1) reaches the host in cycle k. The timeout response fires in cycle TimeoutCycles.
- **Simultaneous events:** a device rvalid in the timeout cycle wins and its data and err are forwarded unchanged.
- **Next grant:** the earliest next grant is the cycle after a response. There is no same-cycle response plus re-grant.
- **Single host:** with NrHosts=1 the pointer stays at 0 and arbitration degenerates to a pass-through.

## Test plan
- **Single access:** host0 writes 0xDEADBEEF to 0x00100004 with be=0xF, and RAM responds after 1 cycle.
  - Cycle 0: `host_gnt_o[0]=1`, `device_req_o[0]=1` with identical fields.
  - Cycle 1: `host_rvalid_o[0]=1`, err=0.
- **Round-robin:** hosts 0 and 1 request continuously. Grants alternate 0,1,0,1 on cycles 0,2,4,6. Then reset and make host1 the only requester: it is granted first.
- **Decode miss:** host1 reads 0x00000000.
  - Cycle 0: grant, with no `device_req_o` asserted.
  - Cycle 1: `host_rvalid_o[1]=1`, `host_err_o[1]=1`, rdata=0.
- **Timeout:** TimeoutCycles=8, host0 reads 0x00030000, timer never responds.
  - Cycle 8: err response.
  - A device rvalid in cycle 10 produces no host rvalid.
  - Repeat with the device rvalid in cycle 8: data is forwarded with err=0.
- **Slow device with contention:** a 3-cycle device serves host0 while host1 requests from cycle 1. Host0 gets rvalid in cycle 3, and `host_gnt_o[1]` rises in cycle 4.
- **Reset mid-transaction:** assert `rst_i` in cycle 2 of WAIT_RSP. All outputs are 0 from the next cycle and `rr_ptr=0`, and the device's later rvalid yields no host response.
